// File: rtl/axis_frame_gen.sv
// AXI-Stream test-frame generator.
// Emits frames of a latched length, count and gap. The payload is a rolling
// byte pattern of (frame_seq + byte_index) mod 256. Outputs are decoded
// combinationally from the held beat state, so they stay stable under backpressure.
module axis_frame_gen #(
   parameter int N_SYMBOLS = 8,
   parameter int W_SYMBOL  = 8,
   parameter int MIN_LEN   = 60,
   parameter int MAX_LEN   = 1514
) (
   input  logic                          i_tx_clk,
   input  logic                          i_tx_reset_n,
   input  logic                          i_start,
   input  logic                          i_stop,
   input  logic [15:0]                   i_frame_len,
   input  logic [15:0]                   i_frame_count,
   input  logic [7:0]                    i_gap,
   output logic                          m_axis_tvalid,
   output logic [N_SYMBOLS*W_SYMBOL-1:0] m_axis_tdata,
   output logic [N_SYMBOLS-1:0]          m_axis_tkeep,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   output logic                          o_busy,
   output logic                          o_done,
   output logic [31:0]                   o_frames_sent
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t      state, state_nxt;
   logic [15:0] beats_q;     // beats per frame
   logic [15:0] rem_q;       // valid bytes in the final beat (1..N_SYMBOLS)
   logic [15:0] beat_q;      // current beat index within the frame
   logic [15:0] cnt_q;       // requested frame count, 0 = continuous
   logic [15:0] sent_q;      // frames completed since this start
   logic [7:0]  gap_q;
   logic [7:0]  gap_cnt;
   logic [7:0]  seq_q;
   logic        stop_seen;

   logic [15:0] len_clamp, beats_calc, rem_calc;
   logic        xfer, last_beat, frame_end, count_done, finish;
   logic [7:0]  base;

   // Clamp the requested length and derive beat count and final-beat fill
   always_comb begin
      len_clamp = i_frame_len;
      if (i_frame_len < 16'(MIN_LEN))
         len_clamp = 16'(MIN_LEN);
      else if (i_frame_len > 16'(MAX_LEN))
         len_clamp = 16'(MAX_LEN);
      beats_calc = (len_clamp + 16'(N_SYMBOLS - 1)) / 16'(N_SYMBOLS);
      rem_calc   = len_clamp - 16'(N_SYMBOLS) * (beats_calc - 16'd1);
   end

   assign xfer       = (state == S_SEND) && m_axis_tready;
   assign last_beat  = (beat_q == beats_q - 16'd1);
   assign frame_end  = xfer && last_beat;
   assign count_done = (cnt_q != 16'd0) && (sent_q + 16'd1 == cnt_q);
   assign finish     = stop_seen || i_stop || count_done;

   // State register
   always_ff @(posedge i_tx_clk or negedge i_tx_reset_n) begin
      if (!i_tx_reset_n) state <= S_IDLE;
      else               state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (i_start) state_nxt = S_SEND;
         S_SEND: begin
            if (frame_end) begin
               if (finish)             state_nxt = S_IDLE;
               else if (gap_q != 8'd0) state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (i_stop)                state_nxt = S_IDLE;
            else if (gap_cnt == 8'd1)  state_nxt = S_SEND;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame bookkeeping: latch on start, advance beats, count frames, done pulse
   always_ff @(posedge i_tx_clk or negedge i_tx_reset_n) begin
      if (!i_tx_reset_n) begin
         beats_q       <= '0;
         rem_q         <= '0;
         beat_q        <= '0;
         cnt_q         <= '0;
         sent_q        <= '0;
         gap_q         <= '0;
         gap_cnt       <= '0;
         seq_q         <= '0;
         stop_seen     <= 1'b0;
         o_done        <= 1'b0;
         o_frames_sent <= '0;
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  beats_q   <= beats_calc;
                  rem_q     <= rem_calc;
                  beat_q    <= '0;
                  cnt_q     <= i_frame_count;
                  sent_q    <= '0;
                  gap_q     <= i_gap;
                  seq_q     <= '0;
                  // a stop arriving with start still lets exactly one frame out
                  stop_seen <= i_stop;
               end
            end
            S_SEND: begin
               if (i_stop) stop_seen <= 1'b1;
               if (xfer) begin
                  if (last_beat) begin
                     o_frames_sent <= o_frames_sent + 32'd1;
                     seq_q         <= seq_q + 8'd1;
                     sent_q        <= sent_q + 16'd1;
                     beat_q        <= '0;
                     gap_cnt       <= gap_q;
                     stop_seen     <= 1'b0;
                     if (finish) o_done <= 1'b1;
                  end else begin
                     beat_q <= beat_q + 16'd1;
                  end
               end
            end
            S_GAP: begin
               gap_cnt <= gap_cnt - 8'd1;
               if (i_stop) o_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Beat decode: rolling byte pattern, keep mask on the final beat, zeros elsewhere
   always_comb begin
      m_axis_tdata = '0;
      m_axis_tkeep = '0;
      base         = seq_q + beat_q[7:0] * 8'(N_SYMBOLS);
      for (int j = 0; j < N_SYMBOLS; j++) begin
         if ((state == S_SEND) && (!last_beat || (16'(j) < rem_q))) begin
            m_axis_tkeep[j]                      = 1'b1;
            m_axis_tdata[j*W_SYMBOL +: W_SYMBOL] = W_SYMBOL'(base + 8'(j));
         end
      end
   end

   assign m_axis_tvalid = (state == S_SEND);
   assign m_axis_tlast  = (state == S_SEND) && last_beat;
   assign o_busy        = (state != S_IDLE);

endmodule
